// File: rtl/harmonic_mix_sequencer_if.sv
// Bus between the harmonic mix sequencer, the sine/level RAMs, the Fraction scaler and the mix sink.
// The harmonic_limit signal exists only when HARMONIC_LIMIT_EN is defined.
interface harmonic_mix_sequencer_if #(
  parameter int unsigned IDX_BITS     = 6,
  parameter int unsigned DIVISOR_BITS = 7
);
  logic                    sample_tick;
  logic [IDX_BITS-1:0]     level_addr;
  logic [DIVISOR_BITS-1:0] level_data;
  logic [IDX_BITS-1:0]     sine_addr;
  logic [15:0]             sine_data;
  logic                    frac_clear;
  logic                    frac_start;
  logic [DIVISOR_BITS-1:0] frac_multiple;
  logic [15:0]             frac_in;
  logic                    frac_done;
  logic [31:0]             frac_accumulator;
  logic [31:0]             mix_out;
  logic                    mix_valid;
  logic                    busy;
  logic                    overrun;
  logic                    overrun_clear;
`ifdef HARMONIC_LIMIT_EN
  logic [IDX_BITS-1:0]     harmonic_limit;
`endif

  // Sequencer side
  modport master (
    input  sample_tick, level_data, sine_data, frac_done, frac_accumulator, overrun_clear,
`ifdef HARMONIC_LIMIT_EN
    input  harmonic_limit,
`endif
    output level_addr, sine_addr, frac_clear, frac_start, frac_multiple, frac_in,
    output mix_out, mix_valid, busy, overrun
  );

  // Environment side: RAMs, scaler and mix consumer
  modport slave (
    output sample_tick, level_data, sine_data, frac_done, frac_accumulator, overrun_clear,
`ifdef HARMONIC_LIMIT_EN
    output harmonic_limit,
`endif
    input  level_addr, sine_addr, frac_clear, frac_start, frac_multiple, frac_in,
    input  mix_out, mix_valid, busy, overrun
  );
endinterface

// File: rtl/harmonic_mix_sequencer.sv
// Walks all harmonics once per sample tick, driving one shared Fraction scaler, and latches the mix.
// Optional macro HARMONIC_LIMIT_EN adds a per-frame harmonic count limit sampled in CLEAR.
module harmonic_mix_sequencer #(
  parameter int unsigned HARMONICS    = 64,
  parameter int unsigned IDX_BITS     = 6,
  parameter int unsigned DIVISOR_BITS = 7
) (
  input logic                   clk_i,
  input logic                   rst_i,
  harmonic_mix_sequencer_if.master bus
);
  localparam logic [IDX_BITS-1:0] LastIdx = IDX_BITS'(HARMONICS - 1);

  typedef enum logic [3:0] {
    StIdle, StClear, StAddr, StCapture, StIssue, StArm, StWait, StNext, StFinish
  } state_e;

  state_e                  state_q;
  logic [IDX_BITS-1:0]     idx_q;
  logic [IDX_BITS-1:0]     limit_q;
  logic                    frac_clear_q;
  logic                    frac_start_q;
  logic [DIVISOR_BITS-1:0] frac_multiple_q;
  logic [15:0]             frac_in_q;
  logic [31:0]             mix_out_q;
  logic                    mix_valid_q;
  logic                    busy_q;
  logic                    overrun_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q         <= StIdle;
      idx_q           <= '0;
      limit_q         <= '0;
      frac_clear_q    <= 1'b0;
      frac_start_q    <= 1'b0;
      frac_multiple_q <= '0;
      frac_in_q       <= '0;
      mix_out_q       <= '0;
      mix_valid_q     <= 1'b0;
      busy_q          <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      frac_clear_q <= 1'b0;
      frac_start_q <= 1'b0;
      mix_valid_q  <= 1'b0;

      // A tick in any non-idle state (FINISH included) is an overrun; set beats clear.
      if (bus.sample_tick && (state_q != StIdle)) begin
        overrun_q <= 1'b1;
      end else if (bus.overrun_clear) begin
        overrun_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (bus.sample_tick) begin
            state_q      <= StClear;
            frac_clear_q <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        StClear: begin
          idx_q   <= '0;
`ifdef HARMONIC_LIMIT_EN
          limit_q <= (bus.harmonic_limit > LastIdx) ? LastIdx : bus.harmonic_limit;
`else
          limit_q <= LastIdx;
`endif
          state_q <= StAddr;
        end
        StAddr: state_q <= StCapture;
        StCapture: begin
          frac_multiple_q <= bus.level_data;
          frac_in_q       <= bus.sine_data;
          if (bus.level_data == '0) begin
            state_q <= StNext;
          end else begin
            state_q      <= StIssue;
            frac_start_q <= 1'b1;
          end
        end
        StIssue: state_q <= StArm;
        StArm:   state_q <= StWait;
        StWait: begin
          if (bus.frac_done) state_q <= StNext;
        end
        StNext: begin
          if (idx_q == limit_q) begin
            state_q     <= StFinish;
            mix_out_q   <= bus.frac_accumulator;
            mix_valid_q <= 1'b1;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= StAddr;
          end
        end
        StFinish: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.level_addr    = idx_q;
  assign bus.sine_addr     = idx_q;
  assign bus.frac_clear    = frac_clear_q;
  assign bus.frac_start    = frac_start_q;
  assign bus.frac_multiple = frac_multiple_q;
  assign bus.frac_in       = frac_in_q;
  assign bus.mix_out       = mix_out_q;
  assign bus.mix_valid     = mix_valid_q;
  assign bus.busy          = busy_q;
  assign bus.overrun       = overrun_q;
endmodule

// File: tb/tb_harmonic_mix_sequencer.sv
// Scoreboard bench for harmonic_mix_sequencer with behavioural RAMs and Fraction scaler.
module tb_harmonic_mix_sequencer;
  localparam int unsigned H  = 4;
  localparam int unsigned IB = 6;
  localparam int unsigned DB = 7;

  typedef struct {
    logic [31:0] mix;
    int          starts;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  harmonic_mix_sequencer_if #(.IDX_BITS(IB), .DIVISOR_BITS(DB)) bus ();

  harmonic_mix_sequencer #(.HARMONICS(H), .IDX_BITS(IB), .DIVISOR_BITS(DB)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  logic [DB-1:0] level_mem [2**IB];
  logic [15:0]   sine_mem  [2**IB];
  exp_t          sb_q [$];
  int            vectors = 0;
  int            miscompares = 0;
  int            n_starts = 0;
  int            n_clears = 0;
  int            limit_val = H - 1;

  function automatic int scale(input logic [15:0] s, input logic [DB-1:0] l);
    int p;
    p = int'($signed(s)) * int'(l);
    return p >>> DB;
  endfunction

  // 1-cycle latency RAMs
  always @(posedge clk) begin
    bus.level_data <= level_mem[bus.level_addr];
    bus.sine_data  <= sine_mem[bus.sine_addr];
  end

  // Fraction scaler: async clear, done drops after start, random run time
  int acc_cnt;
  int acc_prod;
  always @(posedge clk or posedge rst or posedge bus.frac_clear) begin
    if (rst || bus.frac_clear) begin
      bus.frac_accumulator <= '0;
      bus.frac_done        <= 1'b1;
      acc_cnt              <= 0;
    end else if (bus.frac_start) begin
      bus.frac_done <= 1'b0;
      acc_cnt       <= int'($urandom_range(0, 3));
      acc_prod      <= scale(bus.frac_in, bus.frac_multiple);
    end else if (!bus.frac_done) begin
      if (acc_cnt == 0) begin
        bus.frac_accumulator <= bus.frac_accumulator + 32'(acc_prod);
        bus.frac_done        <= 1'b1;
      end else begin
        acc_cnt <= acc_cnt - 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  // Monitor: operand checks on each start, scoreboard pop on each mix_valid
  always @(negedge clk) begin
    if (rst) begin
      n_starts = 0;
      n_clears = 0;
    end else begin
      if (bus.frac_clear) n_clears++;
      if (bus.frac_start) begin
        n_starts++;
        check("clear_before_start", 32'(n_clears), 32'd1);
        check("start_multiple", 32'(bus.frac_multiple), 32'(level_mem[bus.level_addr]));
        check("start_in", 32'(bus.frac_in), 32'(sine_mem[bus.sine_addr]));
      end
      if (bus.mix_valid) begin
        if (sb_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_mix_valid: got mix_out 0x%08h, expected no pulse", bus.mix_out);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("mix_out", bus.mix_out, e.mix);
          check("start_count", 32'(n_starts), 32'(e.starts));
          check("clear_count", 32'(n_clears), 32'd1);
        end
        n_starts = 0;
        n_clears = 0;
      end
    end
  end

  function automatic exp_t model();
    exp_t e;
    int   last;
    e.mix    = '0;
    e.starts = 0;
    last     = (limit_val < int'(H) - 1) ? limit_val : int'(H) - 1;
    for (int k = 0; k <= last; k++) begin
      if (level_mem[k] != '0) begin
        e.mix = e.mix + 32'(scale(sine_mem[k], level_mem[k]));
        e.starts++;
      end
    end
    return e;
  endfunction

  task automatic load(input int l0, input int l1, input int l2, input int l3,
                      input int s0, input int s1, input int s2, input int s3);
    level_mem[0] = DB'(l0); level_mem[1] = DB'(l1);
    level_mem[2] = DB'(l2); level_mem[3] = DB'(l3);
    sine_mem[0] = 16'(s0); sine_mem[1] = 16'(s1);
    sine_mem[2] = 16'(s2); sine_mem[3] = 16'(s3);
  endtask

  task automatic tick();
    bus.sample_tick = 1'b1;
    @(negedge clk);
    bus.sample_tick = 1'b0;
  endtask

  task automatic start_frame();
`ifdef HARMONIC_LIMIT_EN
    bus.harmonic_limit = IB'(limit_val);
`endif
    sb_q.push_back(model());
    tick();
  endtask

  task automatic wait_mix(input string name);
    int n = 0;
    while (!bus.mix_valid && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_mix_valid_seen"}, 32'(bus.mix_valid), 32'd1);
    @(negedge clk);
    check({name, "_busy_after"}, 32'(bus.busy), 32'd0);
    check({name, "_single_pulse"}, 32'(bus.mix_valid), 32'd0);
  endtask

  initial begin
    bus.sample_tick   = 1'b0;
    bus.overrun_clear = 1'b0;
`ifdef HARMONIC_LIMIT_EN
    bus.harmonic_limit = IB'(H - 1);
`endif
    for (int i = 0; i < 2**IB; i++) begin
      level_mem[i] = '0;
      sine_mem[i]  = '0;
    end
    repeat (3) @(negedge clk);
    check("rst_level_addr", 32'(bus.level_addr), 32'd0);
    check("rst_sine_addr", 32'(bus.sine_addr), 32'd0);
    check("rst_frac_clear", 32'(bus.frac_clear), 32'd0);
    check("rst_frac_start", 32'(bus.frac_start), 32'd0);
    check("rst_frac_multiple", 32'(bus.frac_multiple), 32'd0);
    check("rst_frac_in", 32'(bus.frac_in), 32'd0);
    check("rst_mix_out", bus.mix_out, 32'd0);
    check("rst_mix_valid", 32'(bus.mix_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_overrun", 32'(bus.overrun), 32'd0);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_busy", 32'(bus.busy), 32'd0);

    // Single nonzero harmonic, rest skipped
    load(64, 0, 0, 0, 1000, 77, -5, 300);
    start_frame();
    wait_mix("single");
    check("single_mix_hold", bus.mix_out, 32'd500);

    // All harmonics, negative result, plus an overrun tick mid-frame
    load(127, 127, 127, 127, -256, -256, -256, -256);
    start_frame();
    repeat (6) @(negedge clk);
    tick();
    wait_mix("full");
    check("full_mix_hold", bus.mix_out, 32'hFFFF_FC08);
    check("overrun_set", 32'(bus.overrun), 32'd1);
    bus.overrun_clear = 1'b1;
    @(negedge clk);
    bus.overrun_clear = 1'b0;
    check("overrun_cleared", 32'(bus.overrun), 32'd0);

    // Reset while harmonic 2 is in flight
    start_frame();
    begin
      int n = 0;
      while (!(bus.busy && bus.level_addr == 2 && !bus.frac_start && !bus.frac_done) && n < 500)
      begin
        @(negedge clk);
        n++;
      end
      check("reached_h2_wait", 32'(n < 500), 32'd1);
    end
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_mix_out", bus.mix_out, 32'd0);
    check("midrst_mix_valid", 32'(bus.mix_valid), 32'd0);
    repeat (40) @(negedge clk);
    load(64, 0, 0, 0, 1000, 77, -5, 300);
    start_frame();
    wait_mix("after_rst");
    check("after_rst_mix", bus.mix_out, 32'd500);

`ifdef HARMONIC_LIMIT_EN
    load(64, 64, 64, 64, 1000, 1000, 1000, 1000);
    limit_val = 1;
    start_frame();
    wait_mix("limit1");
    check("limit1_mix", bus.mix_out, 32'd1000);
`endif

    // Randomized frames
    for (int f = 0; f < 12; f++) begin
      for (int k = 0; k < int'(H); k++) begin
        level_mem[k] = ($urandom_range(0, 3) == 0) ? '0 : DB'($urandom_range(1, 127));
        sine_mem[k]  = 16'($urandom);
      end
`ifdef HARMONIC_LIMIT_EN
      limit_val = int'($urandom_range(0, 7));
`endif
      start_frame();
      wait_mix("rand");
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
